arb_request_agent: RTL and testbench

ARB_REQUEST_AGENT -- requirements
Module: arb_request_agent

---
 rtl/arb_request_agent.sv | 120 ++++++++++++
 tb/tb_arb_request_agent.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_request_agent.sv
// arb_request_agent
//   Collects per-port request pulses into saturating pending counters, presents a
//   request vector to an external priority arbiter, and turns each legal grant into
//   a binary index delivered over a valid/ready handshake.
//
// Ports
//   clk_i        : clock, all state updates on the rising edge
//   rst_i        : synchronous active-high reset
//   event_i      : per-port single-cycle request pulses
//   req_o        : request vector to the arbiter (registered state and idx_ready_i only)
//   gnt_i        : grant vector from the arbiter, expected one-hot or zero
//   idx_o        : binary index of the last accepted grant
//   idx_valid_o  : idx_o holds an undelivered grant
//   idx_ready_i  : downstream accepts idx_o
//   overflow_o   : sticky per-port flag, an event was dropped on a saturated counter
//   gnt_err_o    : sticky flag, an illegal grant was observed
module arb_request_agent #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 2,
    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [WIDTH-1:0] event_i,
    output logic [WIDTH-1:0] req_o,
    input  logic [WIDTH-1:0] gnt_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             idx_valid_o,
    input  logic             idx_ready_i,
    output logic [WIDTH-1:0] overflow_o,
    output logic             gnt_err_o
);

    localparam logic [CNT_W-1:0] MaxCnt = '1;

    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0]             idx_q, idx_d;
    logic                        idx_valid_q, idx_valid_d;
    logic [WIDTH-1:0]            overflow_q, overflow_d;
    logic                        gnt_err_q, gnt_err_d;

    logic             stall;
    logic             gnt_onehot;
    logic             gnt_legal;
    logic             gnt_illegal;
    logic [WIDTH-1:0] gnt_hit;
    logic [IdxW-1:0]  gnt_idx;

    // Requests are withheld while the index register is blocked, so any legal grant
    // always finds the register free (empty or draining this cycle).
    always_comb begin
        stall = idx_valid_q & ~idx_ready_i;
        for (int i = 0; i < WIDTH; i++) begin
            req_o[i] = (cnt_q[i] != '0) & ~stall;
        end
    end

    always_comb begin
        gnt_onehot  = (gnt_i != '0) && ((gnt_i & (gnt_i - WIDTH'(1))) == '0);
        gnt_legal   = gnt_onehot && ((gnt_i & ~req_o) == '0);
        gnt_illegal = (gnt_i != '0) && !gnt_legal;
        gnt_hit     = gnt_legal ? gnt_i : '0;
        gnt_idx     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (gnt_i[i]) begin
                gnt_idx = IdxW'(i);
            end
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        for (int i = 0; i < WIDTH; i++) begin
            // A grant and an event on the same port cancel out.
            if (gnt_hit[i] && !event_i[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end else if (!gnt_hit[i] && event_i[i]) begin
                if (cnt_q[i] != MaxCnt) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end else begin
                    overflow_d[i] = 1'b1;
                end
            end
        end

        idx_d       = idx_q;
        idx_valid_d = idx_valid_q;
        if (gnt_legal) begin
            idx_d       = gnt_idx;
            idx_valid_d = 1'b1;
        end else if (idx_valid_q && idx_ready_i) begin
            idx_valid_d = 1'b0;
        end

        gnt_err_d = gnt_err_q | gnt_illegal;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            overflow_q  <= '0;
            gnt_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            idx_valid_q <= idx_valid_d;
            overflow_q  <= overflow_d;
            gnt_err_q   <= gnt_err_d;
        end
    end

    assign idx_o       = idx_q;
    assign idx_valid_o = idx_valid_q;
    assign overflow_o  = overflow_q;
    assign gnt_err_o   = gnt_err_q;

endmodule

// File: tb/tb_arb_request_agent.sv
// Bench for arb_request_agent with WIDTH=4, CNT_W=2 and a fixed-priority arbiter
// (port 0 highest) built from the DUT's req_o. The arbiter can be overridden with
// a forced grant value to model a disconnected or misbehaving arbiter.
module tb_arb_request_agent;

    localparam int MAXC = 3;

    logic       clk;
    logic       rst;
    logic [3:0] ev;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       rdy;
    logic [3:0] ovf;
    logic       err;
    logic       fen;
    logic [3:0] fval;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: pending counts per port, delivery register, sticky flags and
    // a scoreboard of granted indexes still awaiting delivery.
    int       m_cnt[4];
    bit       m_vld;
    int       m_idx;
    bit [3:0] m_ovf;
    bit       m_err;
    int       sb[$];

    arb_request_agent #(
        .WIDTH(4),
        .CNT_W(2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .event_i    (ev),
        .req_o      (req),
        .gnt_i      (gnt),
        .idx_o      (idx),
        .idx_valid_o(vld),
        .idx_ready_i(rdy),
        .overflow_o (ovf),
        .gnt_err_o  (err)
    );

    assign gnt = fen ? fval : (req & (~req + 4'd1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit       stall;
        bit [3:0] mreq;
        bit       legal;
        int       k;
        stall = m_vld && !rdy;
        for (int i = 0; i < 4; i++) mreq[i] = (m_cnt[i] > 0) && !stall;
        chk("m_req", req, mreq);
        chk("m_vld", vld, m_vld);
        if (m_vld) chk("m_idx", idx, m_idx);
        chk("m_ovf", ovf, m_ovf);
        chk("m_err", err, m_err);
        if (rst) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_vld = 0; m_idx = 0; m_ovf = 0; m_err = 0;
            sb.delete();
            return;
        end
        if (m_vld && rdy) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else chk("xfer_idx", idx, sb.pop_front());
        end
        legal = ($countones(gnt) == 1) && ((gnt & ~mreq) == 0);
        if (gnt != 0 && !legal) m_err = 1;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            bit g;
            g = legal && gnt[i];
            if (g) k = i;
            if (g && !ev[i]) m_cnt[i] = m_cnt[i] - 1;
            else if (!g && ev[i]) begin
                if (m_cnt[i] < MAXC) m_cnt[i] = m_cnt[i] + 1;
                else m_ovf[i] = 1;
            end
        end
        if (legal) begin
            m_vld = 1; m_idx = k; sb.push_back(k);
        end else if (m_vld && rdy) begin
            m_vld = 0;
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic fin();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        to_neg();
        fin();
    endtask

    task automatic do_reset();
        rst = 1; ev = 0; fen = 0; fval = 0; rdy = 1;
        tick();
        tick();
        rst = 0;
    endtask

    typedef struct {
        logic [3:0] ev;
        bit         fen;
        logic [3:0] fval;
        logic       rdy;
        logic [3:0] req;
        logic       vld;
        logic [1:0] idx;
        logic       err;
    } vec_t;

    vec_t tbl[10];
    int   xfers;

    initial begin
        rst = 1; ev = 0; fen = 0; fval = 0; rdy = 1;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_vld = 0; m_idx = 0; m_ovf = 0; m_err = 0;

        // Inputs applied in a cycle and outputs expected before that cycle's edge.
        tbl[0] = '{4'b1010, 0, 4'b0000, 1, 4'b0000, 0, 2'd0, 0};
        tbl[1] = '{4'b0000, 0, 4'b0000, 1, 4'b1010, 0, 2'd0, 0};
        tbl[2] = '{4'b0000, 0, 4'b0000, 1, 4'b1000, 1, 2'd1, 0};
        tbl[3] = '{4'b0000, 0, 4'b0000, 1, 4'b0000, 1, 2'd3, 0};
        tbl[4] = '{4'b0001, 1, 4'b0000, 1, 4'b0000, 0, 2'd0, 0};
        tbl[5] = '{4'b0000, 1, 4'b0011, 1, 4'b0001, 0, 2'd0, 0};
        tbl[6] = '{4'b0000, 1, 4'b1000, 1, 4'b0001, 0, 2'd0, 1};
        tbl[7] = '{4'b0000, 1, 4'b0000, 1, 4'b0001, 0, 2'd0, 1};
        tbl[8] = '{4'b0000, 0, 4'b0000, 1, 4'b0001, 0, 2'd0, 1};
        tbl[9] = '{4'b0000, 0, 4'b0000, 1, 4'b0000, 1, 2'd0, 1};

        do_reset();
        to_neg();
        chk("rst_req", req, 4'b0000);
        chk("rst_vld", vld, 1'b0);
        chk("rst_idx", idx, 2'd0);
        chk("rst_ovf", ovf, 4'b0000);
        chk("rst_err", err, 1'b0);
        fin();

        do_reset();
        for (int r = 0; r < 10; r++) begin
            ev = tbl[r].ev; fen = tbl[r].fen; fval = tbl[r].fval; rdy = tbl[r].rdy;
            to_neg();
            chk($sformatf("tbl%0d_req", r), req, tbl[r].req);
            chk($sformatf("tbl%0d_vld", r), vld, tbl[r].vld);
            if (tbl[r].vld) chk($sformatf("tbl%0d_idx", r), idx, tbl[r].idx);
            chk($sformatf("tbl%0d_err", r), err, tbl[r].err);
            fin();
        end

        // Saturation with the arbiter disconnected, then exactly three deliveries.
        do_reset();
        fen = 1; fval = 0;
        for (int p = 0; p < 4; p++) begin
            ev = 4'b0100;
            tick();
        end
        ev = 0;
        to_neg();
        chk("sat_req", req, 4'b0100);
        chk("sat_ovf", ovf, 4'b0100);
        fin();
        fen = 0;
        xfers = 0;
        for (int c = 0; c < 8; c++) begin
            to_neg();
            if (vld && rdy && idx == 2'd2) xfers++;
            fin();
        end
        chk("sat_xfers", xfers, 3);

        // Backpressure: requests withheld and index held until ready returns.
        do_reset();
        ev = 4'b0011;
        tick();
        ev = 0;
        tick();
        rdy = 0;
        for (int c = 0; c < 5; c++) begin
            to_neg();
            chk("bp_req", req, 4'b0000);
            chk("bp_vld", vld, 1'b1);
            chk("bp_idx", idx, 2'd0);
            fin();
        end
        rdy = 1;
        to_neg();
        chk("bp_release_req", req, 4'b0010);
        fin();
        to_neg();
        chk("bp_b2b_vld", vld, 1'b1);
        chk("bp_b2b_idx", idx, 2'd1);
        fin();

        // Event and grant on the same port in the same cycle.
        do_reset();
        fen = 1; fval = 0;
        ev = 4'b0001;
        tick();
        fen = 0;
        to_neg();
        chk("same_req", req, 4'b0001);
        fin();
        ev = 0; fen = 1;
        to_neg();
        chk("same_vld", vld, 1'b1);
        chk("same_idx", idx, 2'd0);
        chk("same_cnt_kept", req, 4'b0001);
        fin();

        // Reset while busy clears everything.
        do_reset();
        fen = 1; fval = 0;
        for (int p = 0; p < 4; p++) begin
            ev = 4'b0100;
            tick();
        end
        ev = 0; fen = 0;
        tick();
        rdy = 0; rst = 1;
        to_neg();
        chk("busy_vld", vld, 1'b1);
        chk("busy_ovf", ovf, 4'b0100);
        fin();
        rst = 0;
        to_neg();
        chk("post_rst_req", req, 4'b0000);
        chk("post_rst_vld", vld, 1'b0);
        chk("post_rst_idx", idx, 2'd0);
        chk("post_rst_ovf", ovf, 4'b0000);
        chk("post_rst_err", err, 1'b0);
        fin();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(99) == 0);
            ev   = 4'($urandom & $urandom);
            rdy  = ($urandom_range(3) != 0);
            fen  = ($urandom_range(15) == 0);
            fval = 4'($urandom);
            tick();
        end

        rst = 0; ev = 0; fen = 0; rdy = 1;
        for (int c = 0; c < 20; c++) tick();
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
